ntt_mult_seq: RTL and testbench

- Sequential shift-add modular pre-multiplier for the mod-65537 (2^16+1) NTT datapath.
- Multiplies two residues and folds the 32-bit unsigned product once, using 2^16 ≡ -1.
- Emits a signed WIDTH-bit value in the input domain of the downstream combinational mod-65537 reducer, which consumes `product` directly.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/ntt_mult_seq_if.sv | 28 ++
 rtl/ntt_mult_seq_mult_fold.sv | 20 ++
 rtl/ntt_mult_seq.sv | 145 ++++++++++++++
 tb/tb_ntt_mult_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the mod-65537 NTT pre-multiplier.
package ntt_pkg;

    // Modulus 2^16 + 1; 2^16 folds to -1.
    localparam int unsigned Q = 65537;
    // Half of the 32-bit product: fold boundary and iteration count.
    localparam int HALF = 16;
    // Residue encoding of 65536 (== -1 mod Q) in a 17-bit operand.
    localparam logic [16:0] NEG_ONE = 17'h10000;
    // Iteration counter width (counts 0..16).
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    // True when a residue operand encodes 65536; lower bits are then don't-care.
    function automatic logic is_neg_one(input logic [16:0] op);
        return (op & NEG_ONE) == NEG_ONE;
    endfunction

endpackage

// File: rtl/ntt_mult_seq_if.sv
// Operand/result handshake bundle for ntt_mult_seq.
interface ntt_mult_seq_if #(
    parameter int WIDTH = 32
);
    localparam int OPW = WIDTH / 2 + 1;

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   a;
    logic [OPW-1:0]   b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
    logic             busy;

    // Producer/consumer side (testbench or upstream datapath).
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/ntt_mult_seq_mult_fold.sv
// Combinational single fold of a 32-bit unsigned product: lo - hi, using
// 2^16 == -1 (mod 65537). Result is signed, range -65535..65535.
module mult_fold
    import ntt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*HALF-1:0] val_i,
    output logic [WIDTH-1:0]  res_o
);

    logic [WIDTH-1:0] lo_ext;
    logic [WIDTH-1:0] hi_ext;

    assign lo_ext = {{(WIDTH-HALF){1'b0}}, val_i[HALF-1:0]};
    assign hi_ext = {{(WIDTH-HALF){1'b0}}, val_i[2*HALF-1:HALF]};
    // Modular-width subtraction yields the two's-complement signed difference.
    assign res_o  = lo_ext - hi_ext;

endmodule

// File: rtl/ntt_mult_seq.sv
// Sequential shift-add modular pre-multiplier for the mod-65537 NTT datapath.
// Multiplies two residues (0..65536) one multiplier bit per cycle, then folds
// the 32-bit product once into a signed value for the downstream reducer.
// Optional build macro NTT_MULT_EARLY_EXIT_EN: leave CALC as soon as the
// remaining multiplier bits are all zero (results unchanged, latency shorter).
module ntt_mult_seq
    import ntt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    ntt_mult_seq_if.slave  bus
);

    state_e            state_q, state_d;
    logic [2*HALF-1:0] ma_q, ma_d;
    logic [HALF-1:0]   mb_q, mb_d;
    logic [2*HALF-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  product_q, product_d;

    logic              accept;
    logic              a_neg, b_neg;
    logic              a_zero, b_zero;
    logic [WIDTH-1:0]  a_ext, b_ext;
    logic [WIDTH-1:0]  special_val;
    logic [HALF-1:0]   mb_shift;
    logic              calc_last;
    logic [WIDTH-1:0]  fold_res;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = product_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Operand classification for the single-cycle special cases.
    assign a_neg  = is_neg_one(bus.a);
    assign b_neg  = is_neg_one(bus.b);
    assign a_zero = (bus.a[HALF-1:0] == '0);
    assign b_zero = (bus.b[HALF-1:0] == '0);
    assign a_ext  = {{(WIDTH-HALF){1'b0}}, bus.a[HALF-1:0]};
    assign b_ext  = {{(WIDTH-HALF){1'b0}}, bus.b[HALF-1:0]};

    // Resolve special-case results: (-1)(-1)=1, (-1)x=-x, 0*x=0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        special_val = '0;
        if (a_neg && b_neg) begin
            special_val = WIDTH'(1);
        end else if (a_neg) begin
            special_val = -b_ext;
        end else if (b_neg) begin
            special_val = -a_ext;
        end
    end

    assign mb_shift = mb_q >> 1;

`ifdef NTT_MULT_EARLY_EXIT_EN
    // Stop once no multiplier bits remain; the counter still bounds the loop.
    assign calc_last = (mb_shift == '0) || (cnt_q == CNT_W'(HALF - 1));
`else
    // Fixed 16 iterations regardless of operand value.
    assign calc_last = (cnt_q == CNT_W'(HALF - 1));
`endif

    mult_fold #(
        .WIDTH (WIDTH)
    ) u_fold (
        .val_i (acc_q),
        .res_o (fold_res)
    );

    // Next-state and datapath update for the IDLE/CALC/FOLD/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (a_neg || b_neg || a_zero || b_zero) begin
                        product_d = special_val;
                        state_d   = DONE;
                    end else begin
                        ma_d    = {{HALF{1'b0}}, bus.a[HALF-1:0]};
                        mb_d    = bus.b[HALF-1:0];
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (mb_q[0]) begin
                    acc_d = acc_q + ma_q;
                end
                ma_d  = ma_q << 1;
                mb_d  = mb_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (calc_last) begin
                    state_d = FOLD;
                end
            end
            FOLD: begin
                product_d = fold_res;
                state_d   = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ma_q      <= '0;
            mb_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q   <= state_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_ntt_mult_seq.sv
// Directed self-checking bench for ntt_mult_seq (default or early-exit build).
module tb_ntt_mult_seq;

    localparam int WIDTH = 32;
    localparam int TMO   = 40;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    ntt_mult_seq_if #(.WIDTH(WIDTH)) bus ();

    ntt_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected cycle (relative to acceptance) at which out_valid rises.
    function automatic int exp_lat(input logic [16:0] a, input logic [16:0] b);
        int k;
        if (a[16] || b[16] || a[15:0] == 16'd0 || b[15:0] == 16'd0) return 1;
`ifdef NTT_MULT_EARLY_EXIT_EN
        k = 0;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        return k + 2;
`else
        k = 16;
        return k + 2;
`endif
    endfunction

    // Issue one operation, check latency and product, then complete it.
    task automatic do_op(input string tag, input logic [16:0] a, input logic [16:0] b,
                         input logic [31:0] exp_p);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!bus.in_ready && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, b)));
        check({tag, "_prod"}, bus.product, exp_p);
        @(negedge clk);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int n_out;
        int n_in;
        int seen_valid;
        logic [16:0] pa[3];
        logic [16:0] pb[3];
        logic [31:0] pe[3];

        n_checks      = 0;
        n_fail        = 0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        // Reset state.
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_product", bus.product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // General and special cases.
        do_op("mul_3x5", 17'd3, 17'd5, 32'h0000000F);
        do_op("mul_max", 17'd65535, 17'd65535, 32'hFFFF0003);
        do_op("neg_a", 17'h10000, 17'd7, 32'hFFFFFFF9);
        do_op("neg_neg", 17'h10000, 17'h10000, 32'h00000001);
        do_op("zero_a", 17'd0, 17'd1234, 32'h00000000);
        do_op("neg_b", 17'd9, 17'h10000, 32'hFFFFFFF7);
        do_op("neg_a_dc", 17'h1FFFF, 17'd5, 32'hFFFFFFFB);
        do_op("mul_1x1", 17'd1, 17'd1, 32'h00000001);

        // Output stall: 1000*300 = 0x493E0 -> 0x93E0 - 0x4 = 0x93DC.
        @(negedge clk);
        bus.a         = 17'd1000;
        bus.b         = 17'd300;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < TMO) begin
            check("stall_busy_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("stall_lat", 32'(lat), 32'(exp_lat(17'd1000, 17'd300)));
        for (int i = 0; i < 5; i++) begin
            check("stall_prod", bus.product, 32'h000093DC);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_busy", 32'(bus.busy), 32'd0);
        check("stall_release_valid", 32'(bus.out_valid), 32'd0);
        check("stall_hold_prod", bus.product, 32'h000093DC);

        // Reset in the middle of a general operation.
        bus.a        = 17'd40000;
        bus.b        = 17'd50000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i < 8; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid++;
        end
        check("abort_no_valid", 32'(seen_valid), 32'd0);
        check("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
        do_op("post_abort_2x2", 17'd2, 17'd2, 32'h00000004);

        // Back-to-back with in_valid held high.
        pa[0] = 17'h10000; pb[0] = 17'd7;     pe[0] = 32'hFFFFFFF9;
        pa[1] = 17'd3;     pb[1] = 17'd5;     pe[1] = 32'h0000000F;
        pa[2] = 17'd100;   pb[2] = 17'd200;   pe[2] = 32'h00004E20;
        n_in  = 0;
        n_out = 0;
        lat   = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.a        = pa[0];
        bus.b        = pb[0];
        bus.in_valid = 1'b1;
        while (n_out < 3 && lat < 200) begin
            if (bus.out_valid) begin
                check("b2b_prod", bus.product, pe[n_out]);
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                check("b2b_accept_idle", 32'(bus.busy), 32'd0);
                n_in++;
                @(negedge clk);
                if (n_in < 3) begin
                    bus.a = pa[n_in];
                    bus.b = pb[n_in];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
            lat++;
        end
        check("b2b_n_in", 32'(n_in), 32'd3);
        check("b2b_n_out", 32'(n_out), 32'd3);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.out_valid) n_out++;
        end
        check("b2b_no_dup", 32'(n_out), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
